// File: rtl/issue_buffer_mp.sv
// Multi-port in-order issue buffer: compacting multi-lane push, head window of OUT_PORTS
// entries, variable pop, flush. Outputs are decoded from registered state only.
module issue_buffer_mp #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned IN_PORTS  = 2,
  parameter int unsigned OUT_PORTS = 2,
  parameter int unsigned AF_MARGIN = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_flush,
  input  logic [IN_PORTS-1:0]              i_valid,
  input  logic [IN_PORTS*WIDTH-1:0]        i_data,
  output logic                             o_ready,
  input  logic [$clog2(OUT_PORTS+1)-1:0]   i_pop_num,
  output logic [OUT_PORTS-1:0]             o_valid,
  output logic [OUT_PORTS*WIDTH-1:0]       o_data,
  output logic [$clog2(DEPTH):0]           o_count,
  output logic                             o_empty,
  output logic                             o_almost_full
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rd_ptr;
  logic [PW-1:0]    r_wr_ptr;
  logic [CW-1:0]    r_count;

  logic             w_ready;
  logic             w_clear;
  logic [CW-1:0]    w_push_n;
  logic [CW-1:0]    w_eff;
  logic [IN_PORTS-1:0] w_we;
  logic [PW-1:0]    w_waddr [IN_PORTS];

  // Ready depends only on the registered count so a same-cycle pop cannot raise it.
  always_comb begin
    w_ready = 32'(r_count) <= (DEPTH - IN_PORTS);
    w_clear = rst | i_flush;
  end

  // Compaction: each set lane lands at wr_ptr + (number of set lanes below it).
  always_comb begin
    w_push_n = '0;
    w_we     = '0;
    for (int unsigned k = 0; k < IN_PORTS; k++) begin
      w_waddr[k] = r_wr_ptr;
      if (i_valid[k] && w_ready && !w_clear) begin
        w_we[k]    = 1'b1;
        w_waddr[k] = r_wr_ptr + PW'(w_push_n);
        w_push_n   = w_push_n + CW'(1);
      end
    end
  end

  // Pop saturates at the pre-push occupancy and at the window width.
  always_comb begin
    w_eff = CW'(i_pop_num);
    if (w_eff > r_count)
      w_eff = r_count;
    if (w_eff > CW'(OUT_PORTS))
      w_eff = CW'(OUT_PORTS);
  end

  always_ff @(posedge clk) begin
    if (w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + PW'(w_push_n);
      r_rd_ptr <= r_rd_ptr + PW'(w_eff);
      r_count  <= r_count + w_push_n - w_eff;
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned k = 0; k < IN_PORTS; k++) begin
      if (w_we[k])
        r_mem[w_waddr[k]] <= i_data[k*WIDTH +: WIDTH];
    end
  end

  always_comb begin
    o_ready       = w_ready;
    o_count       = r_count;
    o_empty       = (r_count == '0);
    o_almost_full = (DEPTH - 32'(r_count)) < AF_MARGIN;
    o_valid       = '0;
    o_data        = '0;
    for (int unsigned k = 0; k < OUT_PORTS; k++) begin
      o_valid[k] = r_count > CW'(k);
      if (o_valid[k])
        o_data[k*WIDTH +: WIDTH] = r_mem[r_rd_ptr + PW'(k)];
    end
  end

endmodule

// File: tb/tb_issue_buffer_mp.sv
// Bench for issue_buffer_mp: directed scenarios plus random traffic, all checked
// against a queue model of the buffer contents.
module tb_issue_buffer_mp;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned INP   = 2;
  localparam int unsigned OUTP  = 2;
  localparam int unsigned AFM   = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    i_flush;
  logic [INP-1:0]          i_valid;
  logic [INP*WIDTH-1:0]    i_data;
  logic                    o_ready;
  logic [1:0]              i_pop_num;
  logic [OUTP-1:0]         o_valid;
  logic [OUTP*WIDTH-1:0]   o_data;
  logic [4:0]              o_count;
  logic                    o_empty;
  logic                    o_almost_full;

  issue_buffer_mp #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .IN_PORTS(INP), .OUT_PORTS(OUTP), .AF_MARGIN(AFM)
  ) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush), .i_valid(i_valid), .i_data(i_data),
    .o_ready(o_ready), .i_pop_num(i_pop_num), .o_valid(o_valid), .o_data(o_data),
    .o_count(o_count), .o_empty(o_empty), .o_almost_full(o_almost_full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] q[$];
  logic [WIDTH-1:0] id;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare every output against what the model's contents imply.
  task automatic check_all();
    int sz;
    sz = q.size();
    chk("count", 64'(o_count), 64'(sz));
    chk("empty", 64'(o_empty), 64'(sz == 0));
    chk("ready", 64'(o_ready), 64'(sz <= int'(DEPTH - INP)));
    chk("almost_full", 64'(o_almost_full), 64'((int'(DEPTH) - sz) < int'(AFM)));
    for (int k = 0; k < int'(OUTP); k++) begin
      chk("valid", 64'(o_valid[k]), 64'(sz > k));
      chk("data", o_data[k*WIDTH +: WIDTH], (sz > k) ? q[k] : 64'h0);
    end
  endtask

  // Apply one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic r, input logic f, input logic [1:0] v,
                      input logic [63:0] d0, input logic [63:0] d1, input logic [1:0] p);
    int sz;
    int eff;
    bit rdy;
    rst = r; i_flush = f; i_valid = v; i_data = {d1, d0}; i_pop_num = p;
    if (r || f) begin
      q.delete();
    end else begin
      sz  = q.size();
      rdy = sz <= int'(DEPTH - INP);
      eff = int'(p);
      if (eff > sz) eff = sz;
      if (eff > int'(OUTP)) eff = int'(OUTP);
      for (int i = 0; i < eff; i++) void'(q.pop_front());
      if (rdy && v[0]) q.push_back(d0);
      if (rdy && v[1]) q.push_back(d1);
    end
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    rst = 1'b1; i_flush = 1'b0; i_valid = '0; i_data = '0; i_pop_num = '0;
    @(negedge clk);

    // Reset values
    step(1, 0, 2'b11, 64'h5, 64'h6, 2'd2);
    chk("rst_valid", 64'(o_valid), 64'h0);
    chk("rst_data", o_data[63:0] | o_data[127:64], 64'h0);
    chk("rst_ready", 64'(o_ready), 64'h1);
    chk("rst_empty", 64'(o_empty), 64'h1);

    // Dual push becomes visible next cycle in lane order
    step(0, 0, 2'b11, 64'h11, 64'h22, 2'd0);
    chk("t1_lane0", o_data[63:0], 64'h11);
    chk("t1_lane1", o_data[127:64], 64'h22);
    chk("t1_valid", 64'(o_valid), 64'h3);

    // Compaction: lane 1 alone lands at the head
    step(1, 0, 2'b00, 64'h0, 64'h0, 2'd0);
    step(0, 0, 2'b10, 64'hDEAD, 64'h33, 2'd0);
    chk("t2_lane0", o_data[63:0], 64'h33);
    chk("t2_lane1", o_data[127:64], 64'h0);
    chk("t2_valid", 64'(o_valid), 64'h1);

    // Streaming across pointer wrap, pop 2 every cycle after the first
    step(1, 0, 2'b00, 64'h0, 64'h0, 2'd0);
    id = 0;
    for (int c = 0; c < 21; c++) begin
      if (c < 20) step(0, 0, 2'b11, id, id + 1, (c == 0) ? 2'd0 : 2'd2);
      else        step(0, 0, 2'b00, 64'h0, 64'h0, 2'd2);
      if (c < 20) chk("t3_head", o_data[63:0], id);
      chk("t3_cnt_le2", 64'(o_count <= 5'd2), 64'h1);
      id = id + 2;
    end

    // Fill to 15: ready drops, extra pushes dropped, one pop re-opens
    step(1, 0, 2'b00, 64'h0, 64'h0, 2'd0);
    for (int c = 0; c < 7; c++) step(0, 0, 2'b11, rnd64(), rnd64(), 2'd0);
    step(0, 0, 2'b01, rnd64(), rnd64(), 2'd0);
    chk("t4_cnt15", 64'(o_count), 64'd15);
    chk("t4_ready0", 64'(o_ready), 64'h0);
    chk("t4_af1", 64'(o_almost_full), 64'h1);
    step(0, 0, 2'b11, rnd64(), rnd64(), 2'd0);
    chk("t4_drop", 64'(o_count), 64'd15);
    step(0, 0, 2'b00, 64'h0, 64'h0, 2'd1);
    chk("t4_cnt14", 64'(o_count), 64'd14);
    chk("t4_ready1", 64'(o_ready), 64'h1);

    // Flush discards same-cycle push and pop
    step(1, 0, 2'b00, 64'h0, 64'h0, 2'd0);
    for (int c = 0; c < 3; c++) step(0, 0, 2'b11, rnd64(), rnd64(), 2'd0);
    step(0, 1, 2'b11, rnd64(), rnd64(), 2'd2);
    chk("t5_cnt0", 64'(o_count), 64'd0);
    chk("t5_data0", o_data[63:0] | o_data[127:64], 64'h0);

    // Over-pop saturates; next push appears at the correct head
    step(0, 0, 2'b01, 64'hA1, 64'h0, 2'd0);
    step(0, 0, 2'b00, 64'h0, 64'h0, 2'd2);
    chk("t6_cnt0", 64'(o_count), 64'd0);
    step(0, 0, 2'b11, 64'hB1, 64'hB2, 2'd0);
    chk("t6_head", o_data[63:0], 64'hB1);
    step(1, 0, 2'b11, 64'hC1, 64'hC2, 2'd1);
    chk("t6_rst_valid", 64'(o_valid), 64'h0);

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      logic r;
      logic f;
      logic [1:0] p;
      r = ($urandom_range(0, 99) == 0);
      f = ($urandom_range(0, 49) == 0);
      p = 2'($urandom_range(0, (c % 200 < 100) ? 1 : 2));
      if ($urandom_range(0, 7) == 0) p = 2'd3;
      step(r, f, 2'($urandom()), rnd64(), rnd64(), p);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
